// File: rtl/v_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// v_mem_pkg
//
// Shared definitions for the vector RAM arbiter slice.
//
// Contents:
//   VMEM_DW      default data / mask width in bits
//   VMEM_AW      default address width in bits
//   VRAM_RD_LAT  default VRAM read latency in cycles (legal range 1..4)
//   VPORT_VLSU   requester id of the vector load/store unit (port 0)
//   VPORT_SIDE   requester id of the scalar/DMA side path (port 1)
//   vmem_tag_t   {valid, id} pair, used for the read-tag pipeline and the
//                burst-lock owner register
//   other_port   returns the id of the opposite requester
// ---------------------------------------------------------------------------
package v_mem_pkg;

    localparam int VMEM_DW     = 256;
    localparam int VMEM_AW     = 32;
    localparam int VRAM_RD_LAT = 1;

    localparam logic VPORT_VLSU = 1'b0;
    localparam logic VPORT_SIDE = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } vmem_tag_t;

    // With only two requesters the round-robin successor is the other port.
    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/v_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// v_mem_arbiter_if
//
// One requester-side connection to the VRAM arbiter: the request handshake
// plus the read-response return path.
//
// Signals:
//   req_valid  request valid (requester -> arbiter)
//   req_ready  request accepted this cycle (arbiter -> requester)
//   req_we     1 = write, 0 = read
//   req_lock   keep the grant for the next cycle (burst)
//   req_addr   [AW-1:0] address
//   req_mask   [DW-1:0] bit write mask
//   req_wdata  [DW-1:0] write data
//   rsp_valid  read data valid (arbiter -> requester)
//   rsp_rdata  [DW-1:0] read data, 0 when rsp_valid is low
//
// Modports:
//   master  the requester (load/store unit or side path)
//   slave   the arbiter
// ---------------------------------------------------------------------------
interface v_mem_arbiter_if
    import v_mem_pkg::*;
#(
    parameter int DW = VMEM_DW,
    parameter int AW = VMEM_AW
) ();

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic          req_lock;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_mask;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_lock,
        output req_addr,
        output req_mask,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_lock,
        input  req_addr,
        input  req_mask,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/v_mem_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// v_mem_rd_tag_pipe
//
// RD_LAT-deep shift register of read tags. A tag entering at tag_in on the
// edge that accepts a read leaves at tag_out exactly RD_LAT cycles later,
// lined up with the VRAM read data for that access.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-low clear of every stage
//   tag_in   {valid, id} of the read accepted this cycle (valid=0 if none)
//   tag_out  {valid, id} of the read whose data is on the VRAM bus now
// ---------------------------------------------------------------------------
module v_mem_rd_tag_pipe
    import v_mem_pkg::*;
#(
    parameter int RD_LAT = VRAM_RD_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  vmem_tag_t tag_in,
    output vmem_tag_t tag_out
);

    vmem_tag_t [RD_LAT-1:0] stages;

    // Stage 0 captures the incoming tag; every later stage takes its
    // predecessor. Clearing on reset drops any read still in flight, so no
    // response is ever produced for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[RD_LAT-1];

endmodule

// File: rtl/v_mem_arbiter.sv
// ---------------------------------------------------------------------------
// v_mem_arbiter
//
// Shares the single vector RAM port between the vector load/store unit
// (port 0) and the scalar/DMA side path (port 1). Round-robin arbitration
// with an optional burst lock; one access per cycle; read data is routed back
// to the requester that issued the read after RD_LAT cycles.
//
// Parameters:
//   DW      data and mask width in bits
//   AW      address width in bits
//   RD_LAT  VRAM read latency in cycles (1..4)
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   port0        requester 0 (load/store unit), slave side of the interface
//   port1        requester 1 (side path), slave side of the interface
//   vram_ren_o   VRAM read enable
//   vram_wen_o   VRAM write enable
//   vram_addr_o  VRAM address, 0 when idle
//   vram_mask_o  VRAM write mask, 0 when idle or reading
//   vram_din_o   VRAM write data, 0 when idle
//   vram_dout_i  VRAM read data
// ---------------------------------------------------------------------------
module v_mem_arbiter
    import v_mem_pkg::*;
#(
    parameter int DW     = VMEM_DW,
    parameter int AW     = VMEM_AW,
    parameter int RD_LAT = VRAM_RD_LAT
) (
    input  logic           clk,
    input  logic           rst,
    v_mem_arbiter_if.slave port0,
    v_mem_arbiter_if.slave port1,
    output logic           vram_ren_o,
    output logic           vram_wen_o,
    output logic [AW-1:0]  vram_addr_o,
    output logic [DW-1:0]  vram_mask_o,
    output logic [DW-1:0]  vram_din_o,
    input  logic [DW-1:0]  vram_dout_i
);

    logic [1:0]    req_valid;
    logic          last_gnt;
    vmem_tag_t     lock_own;
    logic          gnt_any;
    logic          gnt_id;
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_mask;
    logic [DW-1:0] sel_wdata;
    vmem_tag_t     rd_tag_in;
    vmem_tag_t     rd_tag_out;

    assign req_valid = {port1.req_valid, port0.req_valid};

    // Grant decision for the current cycle. A lock owner that is still
    // requesting always wins; otherwise a lone requester wins, and with both
    // requesting the port that did not win last time goes next. Because the
    // granted port is always a requesting one, a grant is also a transfer.
    // Grant is held off while reset is asserted so every output reads 0
    // during reset even if requesters keep valid high.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = VPORT_VLSU;
        if (rst) begin
            if (lock_own.valid && req_valid[lock_own.id]) begin
                gnt_any = 1'b1;
                gnt_id  = lock_own.id;
            end else if (req_valid == 2'b11) begin
                gnt_any = 1'b1;
                gnt_id  = other_port(last_gnt);
            end else if (req_valid != 2'b00) begin
                gnt_any = 1'b1;
                gnt_id  = req_valid[1] ? VPORT_SIDE : VPORT_VLSU;
            end
        end
    end

    // Request fields of whichever port holds the grant.
    always_comb begin
        sel_we    = port0.req_we;
        sel_lock  = port0.req_lock;
        sel_addr  = port0.req_addr;
        sel_mask  = port0.req_mask;
        sel_wdata = port0.req_wdata;
        if (gnt_id == VPORT_SIDE) begin
            sel_we    = port1.req_we;
            sel_lock  = port1.req_lock;
            sel_addr  = port1.req_addr;
            sel_mask  = port1.req_mask;
            sel_wdata = port1.req_wdata;
        end
    end

    assign port0.req_ready = gnt_any && (gnt_id == VPORT_VLSU);
    assign port1.req_ready = gnt_any && (gnt_id == VPORT_SIDE);

    // VRAM command bus. The mask only means something for writes, so it is
    // forced to 0 on reads as well as on idle cycles.
    assign vram_ren_o  = gnt_any && !sel_we;
    assign vram_wen_o  = gnt_any && sel_we;
    assign vram_addr_o = gnt_any ? sel_addr  : '0;
    assign vram_mask_o = (gnt_any && sel_we) ? sel_mask : '0;
    assign vram_din_o  = gnt_any ? sel_wdata : '0;

    // Arbitration history. Every transfer records the winner and whether it
    // asked to keep the bus. A cycle with no transfer can only happen when
    // nobody (in particular no lock owner) is requesting, which is exactly
    // the "owner dropped valid" release case, so the lock is cleared then.
    // last_gnt resets to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= VPORT_SIDE;
            lock_own <= '0;
        end else if (gnt_any) begin
            last_gnt       <= gnt_id;
            lock_own.valid <= sel_lock;
            lock_own.id    <= gnt_id;
        end else begin
            lock_own <= '0;
        end
    end

    assign rd_tag_in.valid = vram_ren_o;
    assign rd_tag_in.id    = gnt_id;

    v_mem_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (rd_tag_in),
        .tag_out (rd_tag_out)
    );

    // The tag leaving the pipeline names the owner of the data currently on
    // vram_dout_i. At most one read is issued per cycle, so at most one port
    // sees a response in any cycle.
    assign port0.rsp_valid = rd_tag_out.valid && (rd_tag_out.id == VPORT_VLSU);
    assign port1.rsp_valid = rd_tag_out.valid && (rd_tag_out.id == VPORT_SIDE);
    assign port0.rsp_rdata = port0.rsp_valid ? vram_dout_i : '0;
    assign port1.rsp_rdata = port1.rsp_valid ? vram_dout_i : '0;

endmodule

// File: tb/tb_v_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_v_mem_arbiter
//
// Directed bench for v_mem_arbiter. Two instances: dut (RD_LAT=1) for the
// main scenarios and dut3 (RD_LAT=3) for the reset-during-read scenario.
// Expected VRAM commands and read responses are queued when stimulus is
// issued and popped by independent monitors when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_v_mem_arbiter;
    import v_mem_pkg::*;

    localparam int DW = 256;
    localparam int AW = 32;

    typedef struct {
        logic          valid;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] mask;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            cyc;
    } rsp_exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] mask;
        logic [DW-1:0] din;
    } vram_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    rsp_exp_t  rsp_q[$];
    rsp_exp_t  rsp3_q[$];
    vram_exp_t vram_q[$];

    logic          ren, wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] mask, din;
    logic [DW-1:0] dout = '0;

    logic          ren3, wen3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] mask3, din3;
    logic [DW-1:0] dout3 = '0;
    logic          pv1 = 1'b0, pv2 = 1'b0;
    logic [AW-1:0] pa1 = '0, pa2 = '0;

    req_t idle_r;
    req_t w_bp;

    v_mem_arbiter_if #(.DW(DW), .AW(AW)) p0_if ();
    v_mem_arbiter_if #(.DW(DW), .AW(AW)) p1_if ();
    v_mem_arbiter_if #(.DW(DW), .AW(AW)) q0_if ();
    v_mem_arbiter_if #(.DW(DW), .AW(AW)) q1_if ();

    v_mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .port0       (p0_if),
        .port1       (p1_if),
        .vram_ren_o  (ren),
        .vram_wen_o  (wen),
        .vram_addr_o (addr),
        .vram_mask_o (mask),
        .vram_din_o  (din),
        .vram_dout_i (dout)
    );

    v_mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .port0       (q0_if),
        .port1       (q1_if),
        .vram_ren_o  (ren3),
        .vram_wen_o  (wen3),
        .vram_addr_o (addr3),
        .vram_mask_o (mask3),
        .vram_din_o  (din3),
        .vram_dout_i (dout3)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp issue and response cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Read data the VRAM models return for a given address.
    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // VRAM model for dut: one-cycle read latency.
    always @(posedge clk) begin
        if (ren) dout <= rd_pattern(addr);
    end

    // VRAM model for dut3: three-cycle read latency.
    always @(posedge clk) begin
        pv1 <= ren3;
        pa1 <= addr3;
        pv2 <= pv1;
        pa2 <= pa1;
        if (pv2) dout3 <= rd_pattern(pa2);
    end

    function automatic req_t nop();
        req_t r;
        r.valid = 1'b0; r.we = 1'b0; r.lock = 1'b0;
        r.addr = '0; r.mask = '0; r.wdata = '0;
        return r;
    endfunction

    function automatic req_t rd(input logic [AW-1:0] a, input logic lk,
                                input logic [DW-1:0] m = '0);
        req_t r;
        r.valid = 1'b1; r.we = 1'b0; r.lock = lk;
        r.addr = a; r.mask = m; r.wdata = '0;
        return r;
    endfunction

    function automatic req_t wr(input logic [AW-1:0] a, input logic [DW-1:0] m,
                                input logic [DW-1:0] d, input logic lk);
        req_t r;
        r.valid = 1'b1; r.we = 1'b1; r.lock = lk;
        r.addr = a; r.mask = m; r.wdata = d;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveReqs(input bit on3, input req_t r0, input req_t r1);
        if (!on3) begin
            p0_if.req_valid = r0.valid; p0_if.req_we = r0.we; p0_if.req_lock = r0.lock;
            p0_if.req_addr = r0.addr; p0_if.req_mask = r0.mask; p0_if.req_wdata = r0.wdata;
            p1_if.req_valid = r1.valid; p1_if.req_we = r1.we; p1_if.req_lock = r1.lock;
            p1_if.req_addr = r1.addr; p1_if.req_mask = r1.mask; p1_if.req_wdata = r1.wdata;
        end else begin
            q0_if.req_valid = r0.valid; q0_if.req_we = r0.we; q0_if.req_lock = r0.lock;
            q0_if.req_addr = r0.addr; q0_if.req_mask = r0.mask; q0_if.req_wdata = r0.wdata;
            q1_if.req_valid = r1.valid; q1_if.req_we = r1.we; q1_if.req_lock = r1.lock;
            q1_if.req_addr = r1.addr; q1_if.req_mask = r1.mask; q1_if.req_wdata = r1.wdata;
        end
    endtask

    // One cycle of stimulus: drive both requesters, queue what the granted
    // request must produce, check the ready pair, then advance to just after
    // the next rising edge. exp_rdy is the hand-computed {ready1, ready0}.
    task automatic applyStimulus(input bit on3, input req_t r0, input req_t r1,
                                 input logic [1:0] exp_rdy, input bit exp_rsp);
        req_t      g;
        vram_exp_t v;
        rsp_exp_t  e;
        driveReqs(on3, r0, r1);
        if (exp_rdy != 2'b00) begin
            g = exp_rdy[1] ? r1 : r0;
            if (!on3) begin
                v.we   = g.we;
                v.addr = g.addr;
                v.mask = g.we ? g.mask : '0;
                v.din  = g.wdata;
                vram_q.push_back(v);
            end
            if (!g.we && exp_rsp) begin
                e.port = exp_rdy[1] ? VPORT_SIDE : VPORT_VLSU;
                e.data = rd_pattern(g.addr);
                e.cyc  = cyc + (on3 ? 3 : 1);
                if (on3) rsp3_q.push_back(e);
                else     rsp_q.push_back(e);
            end
        end
        @(negedge clk);
        if (!on3) checkOutput("ready", {p1_if.req_ready, p0_if.req_ready}, exp_rdy);
        else      checkOutput("ready3", {q1_if.req_ready, q0_if.req_ready}, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ready", {p1_if.req_ready, p0_if.req_ready}, '0);
        checkOutput("rst_rsp_valid", {p1_if.rsp_valid, p0_if.rsp_valid}, '0);
        checkOutput("rst_rdata", p0_if.rsp_rdata | p1_if.rsp_rdata, '0);
        checkOutput("rst_ren_wen", {ren, wen}, '0);
        checkOutput("rst_addr", addr, '0);
        checkOutput("rst_mask_din", mask | din, '0);
        checkOutput("rst3_ready", {q1_if.req_ready, q0_if.req_ready}, '0);
        checkOutput("rst3_rsp_valid", {q1_if.rsp_valid, q0_if.rsp_valid}, '0);
        checkOutput("rst3_rdata", q0_if.rsp_rdata | q1_if.rsp_rdata, '0);
        checkOutput("rst3_ren_wen", {ren3, wen3}, '0);
        checkOutput("rst3_addr", addr3, '0);
        checkOutput("rst3_mask_din", mask3 | din3, '0);
    endtask

    // Response monitor for dut: every response must match the oldest queued
    // read in port, data and arrival cycle; the other port must stay quiet.
    always @(negedge clk) begin : rsp_monitor
        rsp_exp_t e;
        if (p0_if.rsp_valid || p1_if.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_rsp: got valid=%b%b, expected none",
                         p1_if.rsp_valid, p0_if.rsp_valid);
            end else begin
                e = rsp_q.pop_front();
                checkOutput("rsp_valid", {p1_if.rsp_valid, p0_if.rsp_valid},
                            (e.port == VPORT_SIDE) ? 2'b10 : 2'b01);
                checkOutput("rsp_rdata", (e.port == VPORT_SIDE) ? p1_if.rsp_rdata : p0_if.rsp_rdata, e.data);
                checkOutput("rsp_other_rdata", (e.port == VPORT_SIDE) ? p0_if.rsp_rdata : p1_if.rsp_rdata, '0);
                checkOutput("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // Response monitor for dut3; a response for a read dropped by reset has
    // no queue entry and is reported as unexpected.
    always @(negedge clk) begin : rsp3_monitor
        rsp_exp_t e;
        if (q0_if.rsp_valid || q1_if.rsp_valid) begin
            if (rsp3_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_rsp3: got valid=%b%b, expected none",
                         q1_if.rsp_valid, q0_if.rsp_valid);
            end else begin
                e = rsp3_q.pop_front();
                checkOutput("rsp3_valid", {q1_if.rsp_valid, q0_if.rsp_valid},
                            (e.port == VPORT_SIDE) ? 2'b10 : 2'b01);
                checkOutput("rsp3_rdata", (e.port == VPORT_SIDE) ? q1_if.rsp_rdata : q0_if.rsp_rdata, e.data);
                checkOutput("rsp3_cycle", cyc, e.cyc);
            end
        end
    end

    // VRAM command monitor for dut: each command must match the oldest
    // queued transfer in direction, address, mask and (for writes) data.
    always @(negedge clk) begin : vram_monitor
        vram_exp_t v;
        if (ren || wen) begin
            if (vram_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_vram: got ren=%b wen=%b addr=%0h, expected idle",
                         ren, wen, addr);
            end else begin
                v = vram_q.pop_front();
                checkOutput("vram_ren_wen", {ren, wen}, {!v.we, v.we});
                checkOutput("vram_addr", addr, v.addr);
                checkOutput("vram_mask", mask, v.mask);
                if (v.we) checkOutput("vram_din", din, v.din);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        idle_r = nop();
        w_bp   = wr(32'h500, '1, {32{8'h3C}}, 1'b0);
        driveReqs(1'b0, idle_r, idle_r);
        driveReqs(1'b1, idle_r, idle_r);

        // Reset, then idle and a first single read from port 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, idle_r, idle_r, 2'b00, 1'b0);
        applyStimulus(1'b0, rd(32'h40, 1'b0), idle_r, 2'b01, 1'b1);
        applyStimulus(1'b0, idle_r, idle_r, 2'b00, 1'b0);

        // Port 1 alone, then both ports contending: grants alternate.
        applyStimulus(1'b0, idle_r, rd(32'h80, 1'b0), 2'b10, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, rd(32'h10, 1'b0), rd(32'h20, 1'b0), 2'b01, 1'b1);
            applyStimulus(1'b0, rd(32'h10, 1'b0), rd(32'h20, 1'b0), 2'b10, 1'b1);
        end

        // Masked write, then a read whose requester mask must not reach VRAM.
        applyStimulus(1'b0, wr(32'h100, 256'hFF, {32{8'hA5}}, 1'b0), idle_r, 2'b01, 1'b0);
        applyStimulus(1'b0, idle_r, rd(32'h200, 1'b0, '1), 2'b10, 1'b1);
        applyStimulus(1'b0, rd(32'h44, 1'b0), idle_r, 2'b01, 1'b1);

        // Port 1 burst lock for 4 beats against a waiting port 0.
        applyStimulus(1'b0, rd(32'h300, 1'b0), rd(32'h310, 1'b1), 2'b10, 1'b1);
        applyStimulus(1'b0, rd(32'h300, 1'b0), rd(32'h314, 1'b1), 2'b10, 1'b1);
        applyStimulus(1'b0, rd(32'h300, 1'b0), rd(32'h318, 1'b1), 2'b10, 1'b1);
        applyStimulus(1'b0, rd(32'h300, 1'b0), rd(32'h31C, 1'b0), 2'b10, 1'b1);
        applyStimulus(1'b0, rd(32'h300, 1'b0), rd(32'h320, 1'b0), 2'b01, 1'b1);
        applyStimulus(1'b0, idle_r, rd(32'h320, 1'b0), 2'b10, 1'b1);

        // Port 0 locked while port 1 holds a write; owner drops valid.
        applyStimulus(1'b0, rd(32'h400, 1'b1), w_bp, 2'b01, 1'b1);
        applyStimulus(1'b0, rd(32'h404, 1'b1), w_bp, 2'b01, 1'b1);
        applyStimulus(1'b0, rd(32'h408, 1'b1), w_bp, 2'b01, 1'b1);
        applyStimulus(1'b0, idle_r, w_bp, 2'b10, 1'b0);

        // Lock released by an idle cycle: round-robin resumes.
        applyStimulus(1'b0, rd(32'h440, 1'b1), idle_r, 2'b01, 1'b1);
        applyStimulus(1'b0, idle_r, idle_r, 2'b00, 1'b0);
        applyStimulus(1'b0, rd(32'h444, 1'b0), rd(32'h450, 1'b0), 2'b10, 1'b1);
        applyStimulus(1'b0, rd(32'h444, 1'b0), idle_r, 2'b01, 1'b1);
        repeat (3) applyStimulus(1'b0, idle_r, idle_r, 2'b00, 1'b0);

        // RD_LAT=3 instance: reset one cycle after a read is accepted.
        applyStimulus(1'b1, rd(32'h600, 1'b0), idle_r, 2'b01, 1'b0);
        applyStimulus(1'b1, idle_r, idle_r, 2'b00, 1'b0);
        rst = 1'b0;
        driveReqs(1'b1, rd(32'h610, 1'b0), rd(32'h620, 1'b0));
        driveReqs(1'b0, rd(32'h630, 1'b0), idle_r);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1;
        driveReqs(1'b0, idle_r, idle_r);
        rst = 1'b1;
        applyStimulus(1'b1, rd(32'h700, 1'b0), rd(32'h710, 1'b0), 2'b01, 1'b1);
        applyStimulus(1'b1, idle_r, rd(32'h710, 1'b0), 2'b10, 1'b1);
        repeat (6) applyStimulus(1'b1, idle_r, idle_r, 2'b00, 1'b0);

        checkOutput("rsp_q_left", rsp_q.size(), '0);
        checkOutput("rsp3_q_left", rsp3_q.size(), '0);
        checkOutput("vram_q_left", vram_q.size(), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/v_mem_arbiter.md
Name: v_mem_arbiter

Overview:
- Shares the single vector RAM port between two requesters: port 0 is the vector load/store unit, port 1 is the scalar/DMA side path.
- Performs round-robin arbitration with an optional burst lock.
- Drives the VRAM control, address, mask and data signals, and routes read data back to the requester that issued the read.
- Sits between the requesters and the VRAM, and replaces the direct pass-through connection.

Parameters:
- DW, 256: data width and mask width in bits, for both requesters and VRAM.
- AW, 32: address width in bits.
- RD_LAT, 1: VRAM read latency in cycles, from ren_o high to dout_i valid; range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  port 0 write (1) or read (0).
- req0_lock  in  1  port 0 keeps the grant for the next cycle (burst).
- req0_addr  in  AW  port 0 address.
- req0_mask  in  DW  port 0 bit write mask.
- req0_wdata  in  DW  port 0 write data.
- rsp0_valid  out  1  port 0 read data valid.
- rsp0_rdata  out  DW  port 0 read data.
- req1_* / rsp1_*  same as port 0, for port 1.
- vram_ren_o  out  1  VRAM read enable.
- vram_wen_o  out  1  VRAM write enable.
- vram_addr_o  out  AW  VRAM address.
- vram_mask_o  out  DW  VRAM write mask.
- vram_din_o  out  DW  VRAM write data.
- vram_dout_i  in  DW  VRAM read data.

Behaviour:
- Grant is combinational within a cycle; req_ready = granted && valid. At most one port is granted per cycle.
- Handshake: a request transfers when valid && ready. Requesters hold addr, we, mask and wdata stable while valid && !ready. Throughput is one access per cycle.
- Arbitration state:
  - last_gnt (1 bit, reset 1): port 0 wins first after reset.
  - lock_own (2 bits: valid + id, reset 0).
- Grant priority order:
  1. If lock_own is valid and the owner's valid is high, the owner wins.
  2. Otherwise, if exactly one port is valid, that port wins.
  3. Otherwise, if both are valid, the port != last_gnt wins.
- On each transfer: last_gnt <= granted id; lock_own <= {req_lock, id}.
- Lock release:
  - Transfer with lock=0 clears lock_own.
  - Owner valid low while locked: lock_own is released that cycle and normal round-robin applies.
- VRAM drive:
  - vram_ren_o = transfer && !we; vram_wen_o = transfer && we.
  - addr, mask and din are muxed from the granted port; they are 0 when idle.
  - vram_mask_o is 0 on reads.
- Read-tag pipeline: RD_LAT stages of {valid, id}. Stage 0 is loaded on a read transfer; stages shift every cycle.
- At the final stage: rsp<id>_valid = 1 and rsp<id>_rdata = vram_dout_i. The other port's rsp_valid = 0. rdata is 0 when not valid.
- Read-response latency is exactly RD_LAT cycles after the accepting edge. Responses return in order and cannot collide, because at most one read is issued per cycle.
- Writes produce no response.
- Simultaneous write from one port and read from the other: only one is granted per cycle. The loser is served the next cycle; no same-cycle bypass is provided.
- Reset values: all outputs 0; last_gnt = 1; lock_own = 0; tag pipeline cleared.
- Reset asserted mid-operation:
  - In-flight reads are dropped and no rsp_valid is produced for them.
  - Requesters must reissue after reset.
  - Outputs go to their reset values immediately (asynchronous reset).

Decomposition:
- Shared package v_mem_pkg:
  - Constants VMEM_DW, VMEM_AW and VRAM_RD_LAT.
  - Port-id localparams VPORT_VLSU = 0 and VPORT_SIDE = 1.
  - Typedef for the tag entry {valid, id}.
- One sub-module: v_mem_rd_tag_pipe, the RD_LAT-deep shift register of tags with async active-low clear.
- Arbitration and muxing stay in the top-level module.

Test Plan:
- Reset then idle: every output 0; first single request, port 0 read at 0x40, is accepted that cycle. At RD_LAT=1, rsp0_valid pulses exactly 1 cycle later with data equal to vram_dout_i; rsp1_valid stays 0.
- Contention: both ports valid continuously with reads at 0x10/0x20 -> grants alternate 0,1,0,1. Each response returns to the correct port after RD_LAT cycles, in order.
- Lock burst: port 1 valid+lock for 4 beats while port 0 is also valid -> port 1 is granted for all 4 cycles. Port 0 is granted on the cycle after port 1's lock=0 beat.
- Write masking: port 0 writes wdata=0xA5..A5 with mask=0x00FF (lower 8 bits set) -> vram_wen_o=1 with that mask and data; no rsp. A following read from port 1 has mask_o=0.
- Backpressure: port 1 valid held for 3 cycles while port 0 is locked -> req1_ready is 0 for those cycles, and port 1's addr and data are forwarded unchanged once granted.
- Reset mid-read: at RD_LAT=3, assert rst one cycle after a read is accepted -> no rsp_valid is ever produced for that read, and all outputs are 0 during reset. After deassertion, port 0 again has first priority.
